// File: rtl/kvs_arb_pkg.sv
// Shared types and helpers for the KVS channel arbiter: flag width default,
// constant log2, and the round-robin grant search.
package kvs_arb_pkg;

    localparam int FLAG_W_DEF = 4;
    localparam int MAX_CH     = 8;

    typedef struct packed {
        logic              vld;
        logic [2:0]        idx;
        logic [MAX_CH-1:0] onehot;
    } rr_gnt_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Search starts one past ptr so the last winner gets lowest priority.
    function automatic rr_gnt_t rr_next(input logic [MAX_CH-1:0] req,
                                        input logic [2:0] ptr, input int n);
        rr_gnt_t    r;
        logic [2:0] c;
        r = '0;
        for (int k = 1; k <= MAX_CH; k++) begin
            if (k <= n && !r.vld) begin
                c = 3'((int'(ptr) + k) % n);
                if (req[c]) begin
                    r.vld       = 1'b1;
                    r.idx       = c;
                    r.onehot[c] = 1'b1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/arb_sync_fifo.sv
// Synchronous FIFO, first-word fall-through (dout valid while !empty), zero extra latency.
// Push is ignored when full; full comes from registered count so a same-cycle pop frees nothing.
module arb_sync_fifo
    import kvs_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [clog2(DEPTH):0]  count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = cnt_q;

    always_comb begin
        cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/kvs_chan_arb.sv
// N-channel request buffer + round-robin issue to one DB port, in-order tag return; request 2 cycles, response 1 cycle.
// Full channel FIFOs drop and count; issue stalls while MAX_OUT requests are outstanding.
module kvs_chan_arb
    import kvs_arb_pkg::*;
#(
    parameter int NCH        = 2,
    parameter int KEY_SIZE   = 96,
    parameter int FLAG_W     = FLAG_W_DEF,
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_OUT    = 16,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH*KEY_SIZE-1:0] ch_key,
    input  logic [NCH*FLAG_W-1:0]   ch_flag,
    input  logic [NCH-1:0]          ch_valid,
    output logic [NCH-1:0]          ch_full,
    output logic [NCH-1:0]          ch_out_valid,
    output logic [NCH*FLAG_W-1:0]   ch_out_flag,
    output logic [KEY_SIZE-1:0]     db_key,
    output logic [FLAG_W-1:0]       db_flag,
    output logic                    db_valid,
    input  logic                    db_out_valid,
    input  logic [FLAG_W-1:0]       db_out_flag,
    output logic [NCH*CNT_W-1:0]    drop_cnt,
    output logic                    err_orphan
);
    localparam int TAG_W = (NCH > 1) ? clog2(NCH) : 1;
    localparam int RW    = KEY_SIZE + FLAG_W;
    localparam int FAW   = clog2(FIFO_DEPTH);
    localparam int TAW   = clog2(MAX_OUT);

    logic [RW-1:0]       fifo_dout [NCH];
    logic [FAW:0]        fifo_cnt  [NCH];
    logic [NCH-1:0]      fifo_full, fifo_empty, pop_vec;
    logic [MAX_CH-1:0]   req8;
    rr_gnt_t             gnt;
    logic                gnt_ok;
    logic [RW-1:0]       sel_d;
    logic [2:0]          rr_q;
    logic                db_valid_q;
    logic [KEY_SIZE-1:0] db_key_q;
    logic [FLAG_W-1:0]   db_flag_q;

    logic [TAG_W-1:0]    tag_dout;
    logic [TAW:0]        tag_cnt;
    logic                tag_empty, tag_pop, tag_full_unused, unused_gnt;
    logic [NCH-1:0]      rsp_vld_d, ch_out_valid_q;
    logic [NCH*FLAG_W-1:0] rsp_flag_d, ch_out_flag_q;
    logic                err_orphan_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CNT_W-1:0] drop_q;

        arb_sync_fifo #(.WIDTH(RW), .DEPTH(FIFO_DEPTH)) u_req_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (ch_valid[i]),
            .pop   (pop_vec[i]),
            .din   ({ch_key[i*KEY_SIZE +: KEY_SIZE], ch_flag[i*FLAG_W +: FLAG_W]}),
            .dout  (fifo_dout[i]),
            .count (fifo_cnt[i]),
            .full  (fifo_full[i]),
            .empty (fifo_empty[i])
        );

        assign ch_full[i] = (fifo_cnt[i] == (FAW+1)'(FIFO_DEPTH));
        assign pop_vec[i] = gnt_ok && gnt.onehot[i];
        assign drop_cnt[i*CNT_W +: CNT_W] = drop_q;

        always_ff @(posedge clk) begin
            if (rst)
                drop_q <= '0;
            else if (ch_valid[i] && fifo_full[i] && drop_q != '1)
                drop_q <= drop_q + CNT_W'(1);
        end
    end

    always_comb begin
        req8           = '0;
        req8[NCH-1:0]  = ~fifo_empty;
        gnt            = rr_next(req8, rr_q, NCH);
        gnt_ok         = gnt.vld && (tag_cnt != (TAW+1)'(MAX_OUT));
        sel_d          = '0;
        for (int i = 0; i < NCH; i++) begin
            if (pop_vec[i]) sel_d = fifo_dout[i];
        end
    end

    assign unused_gnt = ^gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q       <= 3'(NCH - 1);
            db_valid_q <= 1'b0;
            db_key_q   <= '0;
            db_flag_q  <= '0;
        end else begin
            db_valid_q <= gnt_ok;
            if (gnt_ok) begin
                {db_key_q, db_flag_q} <= sel_d;
                rr_q                  <= gnt.idx;
            end
        end
    end

    // Responses come back in issue order, so the tag queue head names the requester.
    arb_sync_fifo #(.WIDTH(TAG_W), .DEPTH(MAX_OUT)) u_tag_q (
        .clk   (clk),
        .rst   (rst),
        .push  (gnt_ok),
        .pop   (tag_pop),
        .din   (gnt.idx[TAG_W-1:0]),
        .dout  (tag_dout),
        .count (tag_cnt),
        .full  (tag_full_unused),
        .empty (tag_empty)
    );

    assign tag_pop = db_out_valid && !tag_empty;

    always_comb begin
        rsp_vld_d  = '0;
        rsp_flag_d = ch_out_flag_q;
        for (int i = 0; i < NCH; i++) begin
            if (tag_pop && tag_dout == TAG_W'(i)) begin
                rsp_vld_d[i]                  = 1'b1;
                rsp_flag_d[i*FLAG_W +: FLAG_W] = db_out_flag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_out_valid_q <= '0;
            ch_out_flag_q  <= '0;
            err_orphan_q   <= 1'b0;
        end else begin
            ch_out_valid_q <= rsp_vld_d;
            ch_out_flag_q  <= rsp_flag_d;
            if (db_out_valid && tag_empty) err_orphan_q <= 1'b1;
        end
    end

    assign db_valid     = db_valid_q;
    assign db_key       = db_key_q;
    assign db_flag      = db_flag_q;
    assign ch_out_valid = ch_out_valid_q;
    assign ch_out_flag  = ch_out_flag_q;
    assign err_orphan   = err_orphan_q;

endmodule

// File: tb/tb_kvs_chan_arb.sv
// Directed bench for kvs_chan_arb at default parameters (NCH=2, FIFO_DEPTH=8, MAX_OUT=16).
module tb_kvs_chan_arb;
    localparam int NCH = 2;
    localparam int KS  = 96;
    localparam int FW  = 4;
    localparam int CW  = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NCH*KS-1:0] ch_key;
    logic [NCH*FW-1:0] ch_flag;
    logic [NCH-1:0]   ch_valid;
    logic [NCH-1:0]   ch_full;
    logic [NCH-1:0]   ch_out_valid;
    logic [NCH*FW-1:0] ch_out_flag;
    logic [KS-1:0]    db_key;
    logic [FW-1:0]    db_flag;
    logic             db_valid;
    logic             db_out_valid;
    logic [FW-1:0]    db_out_flag;
    logic [NCH*CW-1:0] drop_cnt;
    logic             err_orphan;

    kvs_chan_arb dut (
        .clk          (clk),
        .rst          (rst),
        .ch_key       (ch_key),
        .ch_flag      (ch_flag),
        .ch_valid     (ch_valid),
        .ch_full      (ch_full),
        .ch_out_valid (ch_out_valid),
        .ch_out_flag  (ch_out_flag),
        .db_key       (db_key),
        .db_flag      (db_flag),
        .db_valid     (db_valid),
        .db_out_valid (db_out_valid),
        .db_out_flag  (db_out_flag),
        .drop_cnt     (drop_cnt),
        .err_orphan   (err_orphan)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         db_pulses = 0;
    logic [KS-1:0] key_log[$];

    always @(negedge clk) begin
        if (db_valid === 1'b1) begin
            db_pulses++;
            key_log.push_back(db_key);
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        ch_valid     = '0;
        db_out_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ch_full"},  128'(ch_full), 0);
        chk({tag, "_out_vld"},  128'(ch_out_valid), 0);
        chk({tag, "_out_flag"}, 128'(ch_out_flag), 0);
        chk({tag, "_db_valid"}, 128'(db_valid), 0);
        chk({tag, "_db_key"},   128'(db_key), 0);
        chk({tag, "_db_flag"},  128'(db_flag), 0);
        chk({tag, "_drop"},     128'(drop_cnt), 0);
        chk({tag, "_orphan"},   128'(err_orphan), 0);
    endtask

    int base_p;
    int base_k;

    initial begin
        rst = 1'b1; ch_key = '0; ch_flag = '0; ch_valid = '0;
        db_out_valid = 1'b0; db_out_flag = '0;
        tick();
        tick();
        chk_all_zero("rst");
        rst = 1'b0;
        tick();

        // single request/response on channel 0
        ch_key[KS-1:0] = 96'hA5; ch_flag[FW-1:0] = 4'h1; ch_valid = 2'b01;
        tick();
        ch_valid = '0;
        chk("t1_lat1", 128'(db_valid), 0);
        tick();
        chk("t1_db_valid", 128'(db_valid), 1);
        chk("t1_db_key", 128'(db_key), 128'hA5);
        chk("t1_db_flag", 128'(db_flag), 1);
        db_out_valid = 1'b1; db_out_flag = 4'h8;
        tick();
        db_out_valid = 1'b0;
        chk("t1_db_one", 128'(db_valid), 0);
        chk("t1_out_vld", 128'(ch_out_valid), 128'b01);
        chk("t1_out_flag0", 128'(ch_out_flag[FW-1:0]), 8);
        chk("t1_orphan", 128'(err_orphan), 0);
        tick();
        chk("t1_out_vld_end", 128'(ch_out_valid), 0);

        // both channels every cycle: alternating issue order
        do_reset();
        base_k = key_log.size();
        for (int i = 0; i < 6; i++) begin
            ch_key = {96'(100 + i), 96'(i)};
            ch_valid = 2'b11;
            tick();
        end
        ch_valid = '0;
        repeat (14) tick();
        chk("t2_count", 128'(key_log.size() - base_k), 12);
        for (int j = 0; j < 12; j++) begin
            if (base_k + j < key_log.size())
                chk($sformatf("t2_key%0d", j), 128'(key_log[base_k + j]),
                    (j % 2 == 0) ? 128'(j / 2) : 128'(100 + j / 2));
        end
        chk("t2_drop", 128'(drop_cnt), 0);

        // outstanding limit: 20 requests, no responses
        do_reset();
        base_p = db_pulses;
        for (int i = 0; i < 20; i++) begin
            ch_key[KS-1:0] = 96'(i);
            ch_valid = 2'b01;
            tick();
        end
        ch_valid = '0;
        repeat (10) tick();
        chk("t3_pulses16", 128'(db_pulses - base_p), 16);
        chk("t3_full0", 128'(ch_full[0]), 0);
        chk("t3_drop0", 128'(drop_cnt[CW-1:0]), 0);
        db_out_valid = 1'b1; db_out_flag = 4'h3;
        tick();
        db_out_valid = 1'b0;
        chk("t3_rsp_ch0", 128'(ch_out_valid), 128'b01);
        repeat (6) tick();
        chk("t3_pulses17", 128'(db_pulses - base_p), 17);
        chk("t3_key16", 128'(key_log[key_log.size() - 1]), 16);

        // tag queue still full: ch1 overflows its FIFO
        for (int i = 0; i < 12; i++) begin
            ch_key[2*KS-1:KS] = 96'(200 + i);
            ch_valid = 2'b10;
            tick();
            if (i == 6) chk("t4_full_after7", 128'(ch_full[1]), 0);
            if (i == 7) chk("t4_full_after8", 128'(ch_full[1]), 1);
        end
        ch_valid = '0;
        tick();
        chk("t4_drop1", 128'(drop_cnt[2*CW-1:CW]), 4);
        chk("t4_drop0", 128'(drop_cnt[CW-1:0]), 0);
        chk("t4_no_issue", 128'(db_pulses - base_p), 17);

        // reset with 5 outstanding and 3 buffered
        do_reset();
        base_p = db_pulses;
        for (int i = 0; i < 4; i++) begin
            ch_key = {96'(50 + i), 96'(i + 1)};
            ch_valid = 2'b11;
            tick();
        end
        ch_valid = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("t6_issued5", 128'(db_pulses - base_p), 5);
        chk_all_zero("t6");
        rst = 1'b0;
        repeat (10) tick();
        chk("t6_no_issue", 128'(db_pulses - base_p), 5);
        chk("t6_drop", 128'(drop_cnt), 0);

        // orphan response after reset
        db_out_valid = 1'b1; db_out_flag = 4'hC;
        tick();
        db_out_valid = 1'b0;
        chk("t5_orphan", 128'(err_orphan), 1);
        chk("t5_no_out", 128'(ch_out_valid), 0);
        tick();
        chk("t5_no_out2", 128'(ch_out_valid), 0);
        repeat (4) tick();
        chk("t5_sticky", 128'(err_orphan), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_cleared", 128'(err_orphan), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/kvs_chan_arb.md
Name: kvs_chan_arb

Overview:
- Parametrised N-channel front end between the Ethernet KVS request ports and the single db_top query interface.
- Replaces the fixed one-port hookup of eth_top to db_top.
- Buffers each channel's key/flag requests in a per-channel FIFO and issues them one per cycle to the DB under round-robin arbitration.
- Tracks outstanding requests in an in-order tag queue and steers each DB response back to the requesting channel.
- Provides per-channel drop counters and a sticky orphan-response error.

Parameters:
- NCH, 2, number of requesting channels (1..8).
- KEY_SIZE, 96, key width in bits.
- FLAG_W, 4, flag width in bits (in_flag/out_flag).
- FIFO_DEPTH, 8, entries per channel request FIFO (power of 2, ≥2).
- MAX_OUT, 16, maximum outstanding DB requests (power of 2, ≥2).
- CNT_W, 16, width of each per-channel drop counter.

Ports:
- clk  in  1  single clock for all logic (db_clk domain).
- rst  in  1  synchronous, active-high reset.
- ch_key  in  NCH*KEY_SIZE  per-channel request key; channel i occupies bits [i*KEY_SIZE +: KEY_SIZE].
- ch_flag  in  NCH*FLAG_W  per-channel request flag.
- ch_valid  in  NCH  per-channel request strobe; one request per cycle per channel.
- ch_full  out  NCH  per-channel FIFO full indication.
- ch_out_valid  out  NCH  per-channel response strobe.
- ch_out_flag  out  NCH*FLAG_W  per-channel response flag.
- db_key  out  KEY_SIZE  request key to DB.
- db_flag  out  FLAG_W  request flag to DB.
- db_valid  out  1  request strobe to DB.
- db_out_valid  in  1  response strobe from DB; responses return in request order.
- db_out_flag  in  FLAG_W  response flag from DB.
- drop_cnt  out  NCH*CNT_W  per-channel count of requests dropped because the FIFO was full.
- err_orphan  out  1  sticky flag: a DB response arrived with no request outstanding.

Behaviour:
- Reset: all FIFOs and the tag queue empty; RR pointer = NCH-1, so channel 0 has first priority. All outputs are 0: ch_full, ch_out_valid, ch_out_flag, db_valid, db_key, db_flag, drop_cnt, err_orphan.
- Push rule:
  - ch_valid[i] is accepted iff registered count[i] < FIFO_DEPTH.
  - A pop of that FIFO in the same cycle does not free space for the push.
  - On a rejected push, drop_cnt[i] increments and saturates at 2^CNT_W-1.
- ch_full[i] = (count[i] == FIFO_DEPTH), derived from registered state.
- Arbitration and issue, evaluated every cycle:
  - A grant is allowed when at least one FIFO is non-empty and outstanding < MAX_OUT.
  - The grant goes to the first non-empty channel after the RR pointer, with wrap.
  - The granted FIFO is popped; db_key/db_flag/db_valid are registered, so db_valid is high for exactly one cycle per issued request.
  - The RR pointer is set to the granted index.
  - The granted index is pushed into the tag queue.
- When no grant is made: db_valid = 0 and db_key/db_flag hold their last values.
- Request latency: ch_valid sampled at edge E0 into an empty FIFO with no contention gives db_valid high in the cycle following edge E1, i.e. 2 cycles.
- Sustained throughput: 1 request per cycle in aggregate. With all channels busy, each channel gets 1 grant per NCH cycles.
- Response path:
  - On db_out_valid with the tag queue non-empty: pop tag t. On the next cycle ch_out_valid[t] = 1 for one cycle and ch_out_flag[t] = db_out_flag. Response latency is 1 cycle.
  - ch_out_flag slices for other channels hold their last values.
- On db_out_valid with the tag queue empty: the response is dropped, no ch_out_valid is asserted, and err_orphan is set. err_orphan clears only on rst.
- Issue and response in the same cycle are both performed; the outstanding count is unchanged.
- While outstanding == MAX_OUT, issue stalls and requests stay buffered in the FIFOs.
- FIFO and tag-queue pointers are log2(depth) bits, wrapping naturally. Counts are log2(depth)+1 bits.
- rst asserted mid-operation discards all buffered and outstanding requests. Any DB responses arriving after rst deasserts are treated as orphans.

Decomposition:
- Package kvs_arb_pkg holds:
  - the FLAG_W default;
  - a clog2 function;
  - a round-robin next-grant function (request vector, pointer → one-hot grant plus index).
- Sub-module arb_sync_fifo: a parametrised synchronous FIFO with width, depth, push, pop, dout, count, full and empty, where dout is valid whenever not empty. It is instantiated NCH times for requests (width KEY_SIZE+FLAG_W) and once for the tag queue (width clog2(NCH), depth MAX_OUT).

Test Plan:
- NCH=2. Single ch_valid[0] with key=96'hA5, flag=4'h1 → db_valid 2 cycles later carrying key A5, flag 1. Then db_out_valid with flag 4'h8 → ch_out_valid[0] 1 cycle later with ch_out_flag[0]=8; ch_out_valid[1] stays 0.
- Both channels strobe every cycle for 6 cycles, keys ch0=0..5 and ch1=100..105 → db_key order 0,100,1,101,2,102,…, and no drops.
- DB never responds while ch0 sends 20 requests (MAX_OUT=16) → exactly 16 db_valid pulses. 4 requests remain buffered, ch_full[0]=0 at the end, and drop_cnt[0]=0. Returning 1 response → exactly 1 further issue.
- Hold the tag queue full and send 12 requests on ch1 (FIFO_DEPTH=8) → ch_full[1]=1 after the 8th, drop_cnt[1]=4.
- db_out_valid after reset with nothing outstanding → err_orphan=1, all ch_out_valid stay 0, and err_orphan remains set until rst.
- Assert rst with 5 requests outstanding and 3 buffered → all outputs 0 next cycle. After release, no db_valid until a new ch_valid, and drop_cnt=0.
